// File: rtl/muller_c_bank.sv
`default_nettype none
// ============================================================================
// Module      : muller_c_bank
// Description : Bank of clocked Muller C-elements with input synchronisers,
//               symmetric/asymmetric modes, toggle counters and stuck watchdogs.
// Revision    : 1.0 - initial release
// ============================================================================
module muller_c_bank #(
  parameter int CHANNELS    = 4,
  parameter int INPUTS      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [CHANNELS*INPUTS-1:0]  io_in,
  input  logic [CHANNELS-1:0]         mode,
  input  logic [INPUTS-1:0]           plus_mask,
  input  logic [CHANNELS-1:0]         init_val,
  input  logic                        clr_cnt,
  output logic [CHANNELS-1:0]         c_out,
  output logic [CHANNELS*CNT_W-1:0]   toggle_cnt,
  output logic [CHANNELS-1:0]         stuck
);

  localparam int c_n_bits = CHANNELS * INPUTS;
  localparam int c_wd_w   = $clog2(TIMEOUT + 1);

  logic [c_n_bits-1:0] w_sync;

  // Pad inputs are asynchronous; every bit passes its own flop chain.
  if (SYNC_STAGES == 0) begin : g_bypass
    assign w_sync = io_in;
  end else begin : g_sync
    logic [c_n_bits-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
          r_stage[k] <= '0;
        end
      end else begin
        r_stage[0] <= io_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          r_stage[k] <= r_stage[k-1];
        end
      end
    end

    assign w_sync = r_stage[SYNC_STAGES-1];
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};
    localparam logic [c_wd_w-1:0] c_tmo     = c_wd_w'(TIMEOUT);

    logic [INPUTS-1:0] w_s;
    logic              w_set;
    logic              w_rst;
    logic              w_next;
    logic              r_c;
    logic [CNT_W-1:0]  r_cnt;
    logic [c_wd_w-1:0] r_wd;

    assign w_s   = w_sync[c*INPUTS +: INPUTS];
    assign w_set = &w_s;
    // Asymmetric mode: plus-only inputs are ignored when deciding to fall.
    assign w_rst = mode[c] ? ~|(w_s & ~plus_mask) : ~|w_s;

    always_comb begin
      w_next = r_c;
      if (w_set) begin
        w_next = 1'b1;
      end else if (w_rst) begin
        w_next = 1'b0;
      end
    end

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        r_c   <= init_val[c];
        r_cnt <= '0;
        r_wd  <= '0;
      end else begin
        r_c <= w_next;

        if (clr_cnt) begin
          r_cnt <= '0;
        end else if ((w_next != r_c) && (r_cnt != c_cnt_max)) begin
          r_cnt <= r_cnt + 1'b1;
        end

        if (w_set || w_rst) begin
          r_wd <= '0;
        end else if (r_wd != c_tmo) begin
          r_wd <= r_wd + 1'b1;
        end
      end
    end

    assign c_out[c]                   = r_c;
    assign toggle_cnt[c*CNT_W +: CNT_W] = r_cnt;
    assign stuck[c]                   = (r_wd == c_tmo);
  end

endmodule
`default_nettype wire

// File: tb/tb_muller_c_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_muller_c_bank
// Description : Directed self-checking bench for muller_c_bank (CNT_W 8 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muller_c_bank;

  logic        clk;
  logic        rst;
  logic [11:0] io;
  logic [3:0]  md;
  logic [2:0]  pm;
  logic [3:0]  iv;
  logic        clr;

  logic [3:0]  c_out_a, c_out_b;
  logic [31:0] cnt_a;
  logic [7:0]  cnt_b;
  logic [3:0]  stuck_a, stuck_b;

  int n_chk = 0;
  int n_err = 0;

  muller_c_bank #(.CHANNELS(4), .INPUTS(3), .SYNC_STAGES(2), .CNT_W(8), .TIMEOUT(16)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .io_in(io), .mode(md), .plus_mask(pm),
    .init_val(iv), .clr_cnt(clr), .c_out(c_out_a), .toggle_cnt(cnt_a), .stuck(stuck_a)
  );

  muller_c_bank #(.CHANNELS(4), .INPUTS(3), .SYNC_STAGES(2), .CNT_W(2), .TIMEOUT(16)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .io_in(io), .mode(md), .plus_mask(pm),
    .init_val(iv), .clr_cnt(clr), .c_out(c_out_b), .toggle_cnt(cnt_b), .stuck(stuck_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] io;
    logic [3:0]  md;
    logic [3:0]  exp_c;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl [9];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected 2-bit saturating counts derived from the 8-bit expectations.
  function automatic logic [7:0] sat2(input logic [31:0] v);
    logic [7:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[c*2 +: 2] = (v[c*8 +: 8] > 8'd3) ? 2'd3 : v[c*8 +: 2];
    end
    return r;
  endfunction

  initial begin
    // io = {ch3, ch2, ch1, ch0}; cnt = {cnt3, cnt2, cnt1, cnt0}
    tbl[0] = '{12'b000_000_000_111, 4'b0000, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd1}};
    tbl[1] = '{12'b000_000_000_110, 4'b0000, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd1}};
    tbl[2] = '{12'b000_000_000_000, 4'b0000, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd2}};
    tbl[3] = '{12'b000_000_111_000, 4'b0000, 4'b0010, {8'd0, 8'd0, 8'd1, 8'd2}};
    tbl[4] = '{12'b000_000_100_000, 4'b0010, 4'b0000, {8'd0, 8'd0, 8'd2, 8'd2}};
    tbl[5] = '{12'b000_000_111_000, 4'b0010, 4'b0010, {8'd0, 8'd0, 8'd3, 8'd2}};
    tbl[6] = '{12'b000_000_100_000, 4'b0000, 4'b0010, {8'd0, 8'd0, 8'd3, 8'd2}};
    tbl[7] = '{12'b000_000_100_000, 4'b0010, 4'b0000, {8'd0, 8'd0, 8'd4, 8'd2}};
    tbl[8] = '{12'b111_111_000_000, 4'b0000, 4'b1100, {8'd1, 8'd1, 8'd4, 8'd2}};

    rst = 1'b1; io = '0; md = '0; pm = 3'b100; iv = 4'b0101; clr = 1'b0;
    step(2);
    chk("reset_c_out_a", 32'(c_out_a), 32'h5);
    chk("reset_c_out_b", 32'(c_out_b), 32'h5);
    chk("reset_cnt_a", cnt_a, 32'h0);
    chk("reset_cnt_b", 32'(cnt_b), 32'h0);
    chk("reset_stuck", 32'({stuck_b, stuck_a}), 32'h0);

    rst = 1'b0; clr = 1'b1;
    step(4);
    clr = 1'b0;
    chk("init_c_out", 32'(c_out_a), 32'h0);
    chk("init_cnt_a", cnt_a, 32'h0);
    chk("init_cnt_b", 32'(cnt_b), 32'h0);

    for (int i = 0; i < 9; i++) begin
      io = tbl[i].io;
      md = tbl[i].md;
      step(4);
      chk($sformatf("vec%0d_c_out_a", i), 32'(c_out_a), 32'(tbl[i].exp_c));
      chk($sformatf("vec%0d_c_out_b", i), 32'(c_out_b), 32'(tbl[i].exp_c));
      chk($sformatf("vec%0d_cnt_a", i), cnt_a, tbl[i].exp_cnt);
      chk($sformatf("vec%0d_cnt_b", i), 32'(cnt_b), 32'(sat2(tbl[i].exp_cnt)));
      chk($sformatf("vec%0d_stuck", i), 32'({stuck_b, stuck_a}), 32'h0);
    end

    // Latency: c_out follows a pad change on the third edge.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_cnt_a", cnt_a, 32'h0);
    io = 12'b111_111_000_111;
    step(2);
    chk("latency_before", 32'(c_out_a), 32'hC);
    step(1);
    chk("latency_at", 32'(c_out_a), 32'hD);
    chk("latency_cnt", cnt_a, 32'h0000_0001);

    // Watchdog on channel 2.
    io = 12'b111_010_000_111;
    step(17);
    chk("stuck_pre", 32'(stuck_a), 32'h0);
    chk("stuck_hold_c", 32'(c_out_a), 32'hD);
    step(1);
    chk("stuck_set_a", 32'(stuck_a), 32'h4);
    chk("stuck_set_b", 32'(stuck_b), 32'h4);
    io = 12'b111_000_000_111;
    step(2);
    chk("stuck_still", 32'(stuck_a), 32'h4);
    step(1);
    chk("stuck_drop", 32'(stuck_a), 32'h0);
    chk("stuck_drop_c", 32'(c_out_a), 32'h9);

    // Saturation on channel 3, then clear against a coincident toggle.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      io = {((k % 2) == 0) ? 3'b000 : 3'b111, 9'b000_000_111};
      step(4);
    end
    chk("sat_cnt_a", cnt_a, 32'h0500_0000);
    chk("sat_cnt_b", 32'(cnt_b), 32'hC0);
    chk("sat_c_out", 32'(c_out_a), 32'h1);
    io = 12'b111_000_000_111;
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_tog_c_out", 32'(c_out_a), 32'h9);
    chk("clr_tog_cnt_a", cnt_a, 32'h0);
    chk("clr_tog_cnt_b", 32'(cnt_b), 32'h0);
    step(1);
    chk("clr_after_cnt_a", cnt_a, 32'h0);

    // Reset with channel 1 data still in the synchroniser.
    io = 12'b000_000_111_111;
    step(1);
    rst = 1'b1;
    step(1);
    chk("midrst_c_out_a", 32'(c_out_a), 32'h5);
    chk("midrst_c_out_b", 32'(c_out_b), 32'h5);
    chk("midrst_cnt_a", cnt_a, 32'h0);
    chk("midrst_cnt_b", 32'(cnt_b), 32'h0);
    chk("midrst_stuck", 32'({stuck_b, stuck_a}), 32'h0);
    io = 12'b010_010_010_010;
    rst = 1'b0;
    step(1);
    chk("post_rst_c_out_a", 32'(c_out_a), 32'h0);
    chk("post_rst_c_out_b", 32'(c_out_b), 32'h0);
    step(3);
    chk("post_rst_hold", 32'(c_out_a), 32'h0);
    chk("post_rst_cnt_a", cnt_a, 32'h0001_0001);
    chk("post_rst_cnt_b", 32'(cnt_b), 32'h11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
